// File: rtl/branch_seq_ctrl_pkg.sv
// Shared encodings for the branch sequencer: branch types, FSM states, PC reset vector.
// Optional statistics counters are enabled with the BR_STATS_EN macro.
// Pure declarations; no logic lives here besides a saturating-increment helper.
package branch_seq_ctrl_pkg;

  // Branch type field as presented by decode; BR_RSV is never taken.
  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_JMP = 2'b10,
    BR_RSV = 2'b11
  } br_type_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EVAL  = 2'b01,
    ST_FLUSH = 2'b10
  } br_state_e;

  // PC value after reset.
  localparam int PC_RST_VEC = 0;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/branch_seq_ctrl_if.sv
// Decode <-> branch sequencer bus. master = decode/front end, slave = sequencer.
// Statistics signals exist only when BR_STATS_EN is defined.
// Flow control: decode must keep BrReq low while BrBusy is high.
interface branch_seq_ctrl_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);
  logic              Stall;
  logic              BrReq;
  logic [1:0]        BrType;
  logic [DATA_W-1:0] OpA;
  logic [DATA_W-1:0] OpB;
  logic [PC_W-1:0]   Target;
  logic [PC_W-1:0]   PC;
  logic              BrSel;
  logic              BrBusy;
  logic              BrDone;
  logic              Taken;
  logic              Flush;
`ifdef BR_STATS_EN
  logic              StatClr;
  logic [15:0]       BrCount;
  logic [15:0]       TakenCount;

  modport master (
    output Stall, BrReq, BrType, OpA, OpB, Target, StatClr,
    input  PC, BrSel, BrBusy, BrDone, Taken, Flush, BrCount, TakenCount
  );
  modport slave (
    input  Stall, BrReq, BrType, OpA, OpB, Target, StatClr,
    output PC, BrSel, BrBusy, BrDone, Taken, Flush, BrCount, TakenCount
  );
`else
  modport master (
    output Stall, BrReq, BrType, OpA, OpB, Target,
    input  PC, BrSel, BrBusy, BrDone, Taken, Flush
  );
  modport slave (
    input  Stall, BrReq, BrType, OpA, OpB, Target,
    output PC, BrSel, BrBusy, BrDone, Taken, Flush
  );
`endif
endinterface

// File: rtl/branch_seq_ctrl_br_cond_eval.sv
// br_cond_eval: operand compare and take decision from the branch type.
// Latency: purely combinational.
// No backpressure; consumes the sequencer's latched operands.
module br_cond_eval
  import branch_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  br_type_e          br_type_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              take_o
);

  logic eq;

  assign eq = (op_a_i == op_b_i);

  // Map branch type to taken/not-taken; reserved encoding never branches.
  always_comb begin
    take_o = 1'b0;
    case (br_type_i)
      BR_BEQ:  take_o = eq;
      BR_BNE:  take_o = !eq;
      BR_JMP:  take_o = 1'b1;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: owns the PC, resolves branches (IDLE->EVAL->FLUSH) and flushes the front end.
// Latency: BrReq to PC=Target is 2 cycles; BrDone pulses the cycle after EVAL; Flush lasts FLUSH_CYC cycles.
// Backpressure: Stall freezes all state; BrReq only sampled in IDLE. Optional BR_STATS_EN adds counters.
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int DATA_W    = 8,
  parameter int FLUSH_CYC = 2   // 1..15, fits the 4-bit counter
) (
  input  logic             Clk,
  input  logic             Rst,
  branch_seq_ctrl_if.slave bus
);

  localparam logic [3:0]      CNT_INIT = 4'(FLUSH_CYC - 1);
  localparam logic [PC_W-1:0] PC_RST   = PC_W'(PC_RST_VEC);

  br_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  br_type_e          type_q, type_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              taken_q, taken_d;
  logic              busy_q, busy_d;
  logic              flush_q, flush_d;
  logic              take;
  logic [PC_W-1:0]   pc_inc;

  br_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .br_type_i (type_q),
    .op_a_i    (opa_q),
    .op_b_i    (opb_q),
    .take_o    (take)
  );

  assign pc_inc = pc_q + PC_W'(1);

  // Next-state logic; a stall leaves everything at its held value except BrDone,
  // which is forced low so a stalled cycle never repeats the resolve pulse.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    taken_d = taken_q;
    busy_d  = busy_q;
    flush_d = flush_q;
    if (!bus.Stall) begin
      case (state_q)
        ST_IDLE: begin
          pc_d = pc_inc;
          if (bus.BrReq) begin
            tgt_d   = bus.Target;
            opa_d   = bus.OpA;
            opb_d   = bus.OpB;
            type_d  = br_type_e'(bus.BrType);
            state_d = ST_EVAL;
            busy_d  = 1'b1;
          end
        end
        ST_EVAL: begin
          done_d  = 1'b1;
          taken_d = take;
          if (take) begin
            pc_d    = tgt_q;
            cnt_d   = CNT_INIT;
            state_d = ST_FLUSH;
            flush_d = 1'b1;
          end else begin
            pc_d    = pc_inc;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
        ST_FLUSH: begin
          pc_d = pc_inc;
          if (cnt_q == 4'd0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            flush_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  // FSM, PC, latches and registered outputs; reset aborts any branch in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RST;
      tgt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      type_q  <= BR_BEQ;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      busy_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      busy_q  <= busy_d;
      flush_q <= flush_d;
    end
  end

  assign bus.PC     = pc_q;
  assign bus.BrSel  = (state_q == ST_EVAL) && take;
  assign bus.BrBusy = busy_q;
  assign bus.BrDone = done_q;
  assign bus.Taken  = taken_q;
  assign bus.Flush  = flush_q;

`ifdef BR_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] tk_cnt_q, tk_cnt_d;

  // Counters update on the same edge that raises BrDone, so they read
  // consistently with the pulse; clear wins over an increment.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (bus.StatClr) begin
      br_cnt_d = '0;
      tk_cnt_d = '0;
    end else if (done_d) begin
      br_cnt_d = sat_inc16(br_cnt_q);
      if (taken_d) tk_cnt_d = sat_inc16(tk_cnt_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign bus.BrCount    = br_cnt_q;
  assign bus.TakenCount = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl; statistics checks compile in with BR_STATS_EN.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Single linear stimulus sequence with hand-computed expectations.
module tb_branch_seq_ctrl;

  logic Clk;
  logic Rst;
  int   n_cmp;
  int   n_err;

  branch_seq_ctrl_if #(.PC_W(8), .DATA_W(8)) bif ();

  branch_seq_ctrl #(.PC_W(8), .DATA_W(8), .FLUSH_CYC(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic req(input logic [1:0] t, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] tg);
    bif.BrReq  = 1'b1;
    bif.BrType = t;
    bif.OpA    = a;
    bif.OpB    = b;
    bif.Target = tg;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Rst        = 1'b1;
    bif.Stall  = 1'b0;
    bif.BrReq  = 1'b0;
    bif.BrType = 2'b00;
    bif.OpA    = '0;
    bif.OpB    = '0;
    bif.Target = '0;
`ifdef BR_STATS_EN
    bif.StatClr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_pc", bif.PC, 0);
    chk("rst_busy", bif.BrBusy, 0);
    chk("rst_done", bif.BrDone, 0);
    chk("rst_flush", bif.Flush, 0);
    chk("rst_brsel", bif.BrSel, 0);
    chk("rst_taken", bif.Taken, 0);
    Rst = 1'b0;

    // Free run: PC 1..5
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("run_pc", bif.PC, i);
      chk("run_flush", bif.Flush, 0);
      chk("run_busy", bif.BrBusy, 0);
    end

    // BEQ taken at PC=5 -> 0x40
    req(2'b00, 8'h3C, 8'h3C, 8'h40);
    tick();
    bif.BrReq = 1'b0;
    chk("beq_eval_pc", bif.PC, 8'h06);
    chk("beq_eval_busy", bif.BrBusy, 1);
    chk("beq_eval_brsel", bif.BrSel, 1);
    chk("beq_eval_done", bif.BrDone, 0);
    tick();
    chk("beq_pc_tgt", bif.PC, 8'h40);
    chk("beq_done", bif.BrDone, 1);
    chk("beq_taken", bif.Taken, 1);
    chk("beq_flush1", bif.Flush, 1);
    chk("beq_brsel_off", bif.BrSel, 0);
    tick();
    chk("beq_pc41", bif.PC, 8'h41);
    chk("beq_done_pulse", bif.BrDone, 0);
    chk("beq_flush2", bif.Flush, 1);
    tick();
    chk("beq_pc42", bif.PC, 8'h42);
    chk("beq_flush_end", bif.Flush, 0);
    chk("beq_idle", bif.BrBusy, 0);

    // BNE not taken, back-to-back in first IDLE cycle
    req(2'b01, 8'h11, 8'h11, 8'h80);
    tick();
    bif.BrReq = 1'b0;
    chk("bne_eval_pc", bif.PC, 8'h43);
    chk("bne_brsel", bif.BrSel, 0);
    tick();
    chk("bne_pc", bif.PC, 8'h44);
    chk("bne_done", bif.BrDone, 1);
    chk("bne_taken", bif.Taken, 0);
    chk("bne_flush", bif.Flush, 0);
    chk("bne_busy", bif.BrBusy, 0);
    tick();
    chk("bne_pc_seq", bif.PC, 8'h45);
    chk("bne_flush2", bif.Flush, 0);

    // JMP to 0xFC to get near the top of the address space
    req(2'b10, 8'h00, 8'h01, 8'hFC);
    tick();
    bif.BrReq = 1'b0;
    tick();
    chk("jmp1_pc", bif.PC, 8'hFC);
    tick();
    tick();
    chk("jmp1_pc_fe", bif.PC, 8'hFE);
    chk("jmp1_idle", bif.BrBusy, 0);

    // JMP to 0x00 from PC=0xFE
    req(2'b10, 8'h00, 8'h01, 8'h00);
    tick();
    bif.BrReq = 1'b0;
    chk("jmp0_eval_pc", bif.PC, 8'hFF);
    tick();
    chk("jmp0_pc", bif.PC, 8'h00);
    chk("jmp0_taken", bif.Taken, 1);
    tick();
    tick();
    chk("jmp0_pc2", bif.PC, 8'h02);

    // JMP to 0xFF, then PC must wrap to 0x00
    req(2'b10, 8'h00, 8'h00, 8'hFF);
    tick();
    bif.BrReq = 1'b0;
    tick();
    chk("jff_pc", bif.PC, 8'hFF);
    tick();
    chk("wrap_pc", bif.PC, 8'h00);
    tick();
    chk("wrap_pc1", bif.PC, 8'h01);
    chk("wrap_idle", bif.BrBusy, 0);

    // Stall held 3 cycles during FLUSH
    req(2'b00, 8'h05, 8'h05, 8'h20);
    tick();
    bif.BrReq = 1'b0;
    tick();
    chk("stl_pc", bif.PC, 8'h20);
    chk("stl_flush", bif.Flush, 1);
    chk("stl_done", bif.BrDone, 1);
    bif.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_hold_pc", bif.PC, 8'h20);
      chk("stl_hold_flush", bif.Flush, 1);
      chk("stl_no_redone", bif.BrDone, 0);
    end
    bif.Stall = 1'b0;
    tick();
    chk("stl_pc21", bif.PC, 8'h21);
    chk("stl_flush2", bif.Flush, 1);
    tick();
    chk("stl_pc22", bif.PC, 8'h22);
    chk("stl_flush_end", bif.Flush, 0);

    // Reset during EVAL aborts the branch
    req(2'b10, 8'h00, 8'h00, 8'h77);
    tick();
    bif.BrReq = 1'b0;
    chk("rev_eval_busy", bif.BrBusy, 1);
    Rst = 1'b1;
    #1;
    chk("rev_pc", bif.PC, 0);
    chk("rev_busy", bif.BrBusy, 0);
    chk("rev_brsel", bif.BrSel, 0);
    Rst = 1'b0;
    tick();
    chk("rev_pc1", bif.PC, 8'h01);
    chk("rev_no_done", bif.BrDone, 0);
    chk("rev_no_flush", bif.Flush, 0);

    // Target == PC+1 is still taken and flushes
    req(2'b00, 8'h9A, 8'h9A, 8'h03);
    tick();
    bif.BrReq = 1'b0;
    tick();
    chk("seq_tgt_pc", bif.PC, 8'h03);
    chk("seq_tgt_taken", bif.Taken, 1);
    chk("seq_tgt_flush", bif.Flush, 1);
    tick();
    chk("seq_tgt_flush2", bif.Flush, 1);
    tick();
    chk("seq_tgt_pc5", bif.PC, 8'h05);
    chk("seq_tgt_flush_end", bif.Flush, 0);

    // Reserved type with equal operands is not taken
    req(2'b11, 8'h44, 8'h44, 8'hA0);
    tick();
    bif.BrReq = 1'b0;
    chk("rsv_brsel", bif.BrSel, 0);
    tick();
    chk("rsv_pc", bif.PC, 8'h07);
    chk("rsv_done", bif.BrDone, 1);
    chk("rsv_taken", bif.Taken, 0);
    chk("rsv_flush", bif.Flush, 0);

    // Third branch since reset: taken JMP
    req(2'b10, 8'h00, 8'h00, 8'h10);
    tick();
    bif.BrReq = 1'b0;
    tick();
    chk("jmp3_pc", bif.PC, 8'h10);
`ifdef BR_STATS_EN
    chk("stat_br", bif.BrCount, 3);
    chk("stat_tk", bif.TakenCount, 2);
    bif.StatClr = 1'b1;
    tick();
    bif.StatClr = 1'b0;
    chk("stat_br_clr", bif.BrCount, 0);
    chk("stat_tk_clr", bif.TakenCount, 0);
`endif
    tick();
    tick();
    chk("final_idle", bif.BrBusy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
